// File: rtl/fb_scheduler.sv
// Framebuffer RAM arbiter: video reads first, then the clear sequencer, then the
// game-logic write port. Upscales the framebuffer and flags the start of vblank.
module fb_scheduler #(
  parameter int H_ACTIVE   = 800,
  parameter int V_ACTIVE   = 600,
  parameter int SCALE_LOG2 = 2,
  parameter int FB_W       = 200,
  parameter int FB_H       = 150,
  parameter int ADDR_W     = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       nextH,
  input  logic [9:0]        nextV,
  input  logic              nextActive,
  output logic [5:0]        pixel,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [5:0]        ram_wdata,
  input  logic [5:0]        ram_rdata,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [7:0]        wr_x,
  input  logic [7:0]        wr_y,
  input  logic [5:0]        wr_data,
  input  logic              clr_req,
  input  logic [5:0]        clr_color,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              frame_tick
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] FB_W_BITS = ADDR_W'(FB_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_W * FB_H - 1);
  localparam logic [7:0]        FB_W_8    = 8'(FB_W);
  localparam logic [7:0]        FB_H_8    = 8'(FB_H);
  localparam logic [10:0]       H_ACT_11  = 11'(H_ACTIVE);
  localparam logic [9:0]        V_ACT_10  = 10'(V_ACTIVE);

  // Constant-coefficient multiply by FB_W, built from shifted adds only.
  function automatic logic [ADDR_W-1:0] mul_fb_w(input logic [ADDR_W-1:0] v);
    logic [ADDR_W-1:0] acc;
    acc = {ADDR_W{1'b0}};
    for (int i = 0; i < ADDR_W; i++) begin
      if (FB_W_BITS[i]) begin
        acc = acc + (v << i);
      end else begin
        acc = acc;
      end
    end
    return acc;
  endfunction

  state_t            state_r, state_next_s;
  logic [ADDR_W-1:0] clr_cnt_r, clr_cnt_next_s;
  logic [5:0]        clr_color_r, clr_color_next_s;
  logic              clr_done_next_s;
  logic              clr_busy_r, clr_done_r, frame_tick_r;
  logic              vid_rd_q_r, active_q_r;
  logic [5:0]        pixel_reg_r;
  logic              vid_rd_s, wr_in_range_s;
  logic [ADDR_W-1:0] vid_addr_s, wr_addr_s;
  logic [ADDR_W-1:0] ram_addr_s;
  logic [5:0]        ram_wdata_s;
  logic              ram_we_s, wr_ready_s;

  // Range guards keep a misbehaving timing block from reading outside the buffer.
  assign vid_rd_s = nextActive & (nextH < H_ACT_11) & (nextV < V_ACT_10) &
                    (nextH[SCALE_LOG2-1:0] == {SCALE_LOG2{1'b0}});
  assign vid_addr_s = mul_fb_w(ADDR_W'(nextV >> SCALE_LOG2)) + ADDR_W'(nextH >> SCALE_LOG2);
  assign wr_addr_s  = mul_fb_w(ADDR_W'(wr_y)) + ADDR_W'(wr_x);
  assign wr_in_range_s = (wr_x < FB_W_8) & (wr_y < FB_H_8);

  // Per-cycle RAM grant and clear-sequencer next state.
  always_comb begin
    state_next_s     = state_r;
    clr_cnt_next_s   = clr_cnt_r;
    clr_color_next_s = clr_color_r;
    clr_done_next_s  = 1'b0;
    ram_addr_s       = vid_addr_s;
    ram_wdata_s      = 6'd0;
    ram_we_s         = 1'b0;
    wr_ready_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (clr_req) begin
          state_next_s     = ST_CLEAR;
          clr_cnt_next_s   = {ADDR_W{1'b0}};
          clr_color_next_s = clr_color;
        end else begin
          state_next_s = ST_IDLE;
        end
        if (!vid_rd_s) begin
          wr_ready_s = 1'b1;
          if (wr_valid && wr_in_range_s) begin
            ram_we_s    = 1'b1;
            ram_addr_s  = wr_addr_s;
            ram_wdata_s = wr_data;
          end else begin
            ram_we_s = 1'b0;
          end
        end else begin
          ram_addr_s = vid_addr_s;
        end
      end
      ST_CLEAR: begin
        if (!vid_rd_s) begin
          ram_we_s    = 1'b1;
          ram_addr_s  = clr_cnt_r;
          ram_wdata_s = clr_color_r;
          if (clr_cnt_r == LAST_ADDR) begin
            state_next_s    = ST_IDLE;
            clr_done_next_s = 1'b1;
          end else begin
            clr_cnt_next_s = clr_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end else begin
          ram_addr_s = vid_addr_s;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // No RAM writes or handshakes while reset is asserted.
  assign ram_we    = ram_we_s & ~rst;
  assign wr_ready  = wr_ready_s & ~rst;
  assign ram_addr  = ram_addr_s;
  assign ram_wdata = ram_wdata_s;

  // Sequencer, status and video pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      clr_cnt_r    <= {ADDR_W{1'b0}};
      clr_color_r  <= 6'd0;
      clr_busy_r   <= 1'b0;
      clr_done_r   <= 1'b0;
      frame_tick_r <= 1'b0;
      vid_rd_q_r   <= 1'b0;
      active_q_r   <= 1'b0;
      pixel_reg_r  <= 6'd0;
    end else begin
      state_r      <= state_next_s;
      clr_cnt_r    <= clr_cnt_next_s;
      clr_color_r  <= clr_color_next_s;
      clr_busy_r   <= (state_next_s == ST_CLEAR);
      clr_done_r   <= clr_done_next_s;
      frame_tick_r <= (nextH == 11'd0) & (nextV == V_ACT_10);
      vid_rd_q_r   <= vid_rd_s;
      active_q_r   <= nextActive;
      if (vid_rd_q_r) begin
        pixel_reg_r <= ram_rdata;
      end else begin
        pixel_reg_r <= pixel_reg_r;
      end
    end
  end

  // Read data is presented in its own cycle, then held until the next fetch.
  assign pixel      = active_q_r ? (vid_rd_q_r ? ram_rdata : pixel_reg_r) : 6'd0;
  assign clr_busy   = clr_busy_r;
  assign clr_done   = clr_done_r;
  assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_fb_scheduler.sv
// Directed self-checking bench for fb_scheduler: video fetch, port writes,
// clear sequencing, reset abort and vblank tick.
module tb_fb_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] nextH;
  logic [9:0]  nextV;
  logic        nextActive;
  logic [5:0]  pixel;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [5:0]  ram_wdata;
  logic [5:0]  ram_rdata;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_x;
  logic [7:0]  wr_y;
  logic [5:0]  wr_data;
  logic        clr_req;
  logic [5:0]  clr_color;
  logic        clr_busy;
  logic        clr_done;
  logic        frame_tick;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  fb_scheduler dut (
    .clk(clk), .rst(rst), .nextH(nextH), .nextV(nextV), .nextActive(nextActive),
    .pixel(pixel), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x),
    .wr_y(wr_y), .wr_data(wr_data), .clr_req(clr_req), .clr_color(clr_color),
    .clr_busy(clr_busy), .clr_done(clr_done), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_cnt;
    int errs;
    int h;
    logic last;
    logic done;

    rst = 1'b1; nextH = 11'd0; nextV = 10'd0; nextActive = 1'b0; ram_rdata = 6'd0;
    wr_valid = 1'b0; wr_x = 8'd0; wr_y = 8'd0; wr_data = 6'd0;
    clr_req = 1'b0; clr_color = 6'd0;
    tick(); tick();
    #1;
    check_eq("rst_pixel", 32'(pixel), 32'd0);
    check_eq("rst_clr_busy", 32'(clr_busy), 32'd0);
    check_eq("rst_clr_done", 32'(clr_done), 32'd0);
    check_eq("rst_frame_tick", 32'(frame_tick), 32'd0);
    check_eq("rst_ram_we", 32'(ram_we), 32'd0);
    rst = 1'b0;
    tick();

    // video fetch and hold
    nextH = 11'd4; nextV = 10'd8; nextActive = 1'b1; #1;
    check_eq("vid_addr", 32'(ram_addr), 32'd401);
    check_eq("vid_we", 32'(ram_we), 32'd0);
    tick();
    nextH = 11'd5; ram_rdata = 6'h2A; #1;
    check_eq("vid_pixel", 32'(pixel), 32'h2A);
    tick();
    nextH = 11'd6; ram_rdata = 6'h11; #1;
    check_eq("pixel_hold6", 32'(pixel), 32'h2A);
    tick();
    nextH = 11'd7; #1;
    check_eq("pixel_hold7", 32'(pixel), 32'h2A);
    tick();

    // port write blocked on video slot, accepted on the next
    nextH = 11'd8; wr_valid = 1'b1; wr_x = 8'd3; wr_y = 8'd2; wr_data = 6'h15; #1;
    check_eq("wr_ready_vid", 32'(wr_ready), 32'd0);
    check_eq("wr_we_vid", 32'(ram_we), 32'd0);
    tick();
    nextH = 11'd9; #1;
    check_eq("wr_ready", 32'(wr_ready), 32'd1);
    check_eq("wr_we", 32'(ram_we), 32'd1);
    check_eq("wr_addr", 32'(ram_addr), 32'd403);
    check_eq("wr_wdata", 32'(ram_wdata), 32'h15);
    tick();

    // out-of-range drop and corner write in blanking
    nextActive = 1'b0; nextH = 11'd820; wr_x = 8'd200; wr_y = 8'd0; #1;
    check_eq("oor_ready", 32'(wr_ready), 32'd1);
    check_eq("oor_we", 32'(ram_we), 32'd0);
    tick();
    wr_x = 8'd199; wr_y = 8'd149; wr_data = 6'h07; #1;
    check_eq("corner_addr", 32'(ram_addr), 32'd29999);
    check_eq("corner_we", 32'(ram_we), 32'd1);
    check_eq("blank_pixel", 32'(pixel), 32'd0);
    tick();
    wr_x = 8'd0; wr_y = 8'd150; #1;
    check_eq("oor_row_we", 32'(ram_we), 32'd0);
    tick();

    // full clear interleaved with video reads
    wr_valid = 1'b0; clr_req = 1'b1; clr_color = 6'h03; #1;
    tick();
    clr_req = 1'b0; clr_color = 6'h00; wr_valid = 1'b1; wr_x = 8'd5; wr_y = 8'd5;
    exp_cnt = 0; errs = 0; h = 0; done = 1'b0;
    for (int cyc = 0; cyc < 50000 && !done; cyc++) begin
      nextActive = 1'b1; nextV = 10'd4; nextH = 11'(h);
      clr_req = (cyc == 500); clr_color = (cyc == 500) ? 6'h3F : 6'h03;
      last = 1'b0;
      #1;
      if (!clr_busy || wr_ready || clr_done) errs++;
      if (h % 4 == 0) begin
        if (ram_we || ram_addr != 15'(200 + h / 4)) errs++;
      end else begin
        if (!ram_we || ram_addr != 15'(exp_cnt) || ram_wdata != 6'h03) errs++;
        last = (exp_cnt == 29999);
        exp_cnt++;
      end
      tick();
      h = (h + 1) % 800;
      done = last;
    end
    clr_req = 1'b0; wr_valid = 1'b0;
    check_eq("clr_seq_errs", 32'(errs), 32'd0);
    check_eq("clr_write_cnt", 32'(exp_cnt), 32'd30000);
    check_eq("clr_done_pulse", 32'(clr_done), 32'd1);
    check_eq("clr_busy_end", 32'(clr_busy), 32'd0);
    tick();
    check_eq("clr_done_once", 32'(clr_done), 32'd0);

    // reset mid-clear
    nextActive = 1'b0; nextH = 11'd820; nextV = 10'd620;
    clr_req = 1'b1; clr_color = 6'h0C; #1;
    tick();
    clr_req = 1'b0;
    repeat (100) tick();
    check_eq("mid_clr_addr", 32'(ram_addr), 32'd100);
    check_eq("mid_clr_busy", 32'(clr_busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    check_eq("abort_busy", 32'(clr_busy), 32'd0);
    check_eq("abort_done", 32'(clr_done), 32'd0);
    check_eq("abort_we", 32'(ram_we), 32'd0);
    tick();
    check_eq("abort_no_done", 32'(clr_done), 32'd0);
    clr_req = 1'b1; clr_color = 6'h30;
    tick();
    clr_req = 1'b0; #1;
    check_eq("restart_addr", 32'(ram_addr), 32'd0);
    check_eq("restart_we", 32'(ram_we), 32'd1);
    check_eq("restart_data", 32'(ram_wdata), 32'h30);
    tick();

    // vblank tick
    nextH = 11'd0; nextV = 10'd600; #1;
    check_eq("tick_early", 32'(frame_tick), 32'd0);
    tick();
    nextH = 11'd1; #1;
    check_eq("tick_pulse", 32'(frame_tick), 32'd1);
    tick();
    check_eq("tick_single", 32'(frame_tick), 32'd0);
    nextH = 11'd0; nextV = 10'd599;
    tick();
    check_eq("tick_other_line", 32'(frame_tick), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
